// File: rtl/pong_ball_ctrl.sv
// Ball/score controller for a 16-LED pong game on a single game clock.
// Define PONG_SPEEDUP_EN to shorten the step period by one on every successful return.
module pong_ball_ctrl #(
  parameter int STEP_TICKS = 8,
  parameter int HOLD_TICKS = 16,
  parameter int WIN_SCORE  = 7
) (
  input  logic       clk_game,
  input  logic       rst_n,
  input  logic       btn_l,
  input  logic       btn_r,
  output logic [5:0] counter,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over
);

  // One timer serves both the ball step and the point hold, so it must fit either.
  localparam int TW = (HOLD_TICKS > 63) ? $clog2(HOLD_TICKS + 1) : 6;

  localparam logic [5:0] POS_R      = 6'd1;
  localparam logic [5:0] POS_L      = 6'd16;
  localparam logic [5:0] CODE_POINT = 6'd17;
  localparam logic [5:0] CODE_OVER  = 6'd63;
  localparam logic [5:0] STEP_INIT  = 6'(STEP_TICKS);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE,
    MOVE_L,
    MOVE_R,
    POINT,
    OVER
  } state_t;

  state_t          state_q, state_d;
  logic [5:0]      counter_q, counter_d;
  logic [3:0]      score_l_q, score_l_d;
  logic [3:0]      score_r_q, score_r_d;
  logic            game_over_q, game_over_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            hit_q, hit_d;
  logic            btn_l_q, btn_r_q;
  logic            armed_q;
  logic            press_l, press_r;
  logic            step_done, hold_done;
  logic [5:0]      period;

`ifdef PONG_SPEEDUP_EN
  logic [5:0]      period_q, period_d;
  assign period = period_q;
`else
  assign period = STEP_INIT;
`endif

  // armed_q masks the first cycle after reset so a button held through release is not a press.
  assign press_l   = btn_l & ~btn_l_q & armed_q;
  assign press_r   = btn_r & ~btn_r_q & armed_q;
  assign step_done = (timer_q == TW'(period - 6'd1));
  assign hold_done = (timer_q == TW'(HOLD_TICKS - 1));

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    timer_d   = timer_q + TW'(1);
    hit_d     = hit_q;
`ifdef PONG_SPEEDUP_EN
    period_d  = period_q;
`endif
    case (state_q)
      IDLE: begin
        counter_d = 6'd0;
        timer_d   = '0;
        hit_d     = 1'b0;
        if (press_l) begin
          state_d   = MOVE_R;
          counter_d = POS_L;
`ifdef PONG_SPEEDUP_EN
          period_d  = STEP_INIT;
`endif
        end else if (press_r) begin
          state_d   = MOVE_L;
          counter_d = POS_R;
`ifdef PONG_SPEEDUP_EN
          period_d  = STEP_INIT;
`endif
        end
      end
      MOVE_L: begin
        if (counter_q == POS_L && press_l) hit_d = 1'b1;
        if (step_done) begin
          timer_d = '0;
          if (counter_q != POS_L) begin
            counter_d = counter_q + 6'd1;
          end else if (hit_q || press_l) begin
            state_d   = MOVE_R;
            counter_d = POS_L - 6'd1;
            hit_d     = 1'b0;
`ifdef PONG_SPEEDUP_EN
            period_d  = (period_q > 6'd2) ? period_q - 6'd1 : period_q;
`endif
          end else begin
            state_d   = POINT;
            counter_d = CODE_POINT;
            hit_d     = 1'b0;
            if (score_r_q < WIN) score_r_d = score_r_q + 4'd1;
          end
        end
      end
      MOVE_R: begin
        if (counter_q == POS_R && press_r) hit_d = 1'b1;
        if (step_done) begin
          timer_d = '0;
          if (counter_q != POS_R) begin
            counter_d = counter_q - 6'd1;
          end else if (hit_q || press_r) begin
            state_d   = MOVE_L;
            counter_d = POS_R + 6'd1;
            hit_d     = 1'b0;
`ifdef PONG_SPEEDUP_EN
            period_d  = (period_q > 6'd2) ? period_q - 6'd1 : period_q;
`endif
          end else begin
            state_d   = POINT;
            counter_d = CODE_POINT;
            hit_d     = 1'b0;
            if (score_l_q < WIN) score_l_d = score_l_q + 4'd1;
          end
        end
      end
      POINT: begin
        if (hold_done) begin
          timer_d = '0;
          if (score_l_q == WIN || score_r_q == WIN) begin
            state_d   = OVER;
            counter_d = CODE_OVER;
          end else begin
            state_d   = IDLE;
            counter_d = 6'd0;
          end
        end
      end
      OVER: begin
        counter_d = CODE_OVER;
        timer_d   = '0;
        if (press_l || press_r) begin
          state_d   = IDLE;
          counter_d = 6'd0;
          score_l_d = 4'd0;
          score_r_d = 4'd0;
        end
      end
      default: begin
        state_d   = IDLE;
        counter_d = 6'd0;
        timer_d   = '0;
        hit_d     = 1'b0;
      end
    endcase
    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge clk_game or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      counter_q   <= 6'd0;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      game_over_q <= 1'b0;
      timer_q     <= '0;
      hit_q       <= 1'b0;
      btn_l_q     <= 1'b0;
      btn_r_q     <= 1'b0;
      armed_q     <= 1'b0;
`ifdef PONG_SPEEDUP_EN
      period_q    <= STEP_INIT;
`endif
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      game_over_q <= game_over_d;
      timer_q     <= timer_d;
      hit_q       <= hit_d;
      btn_l_q     <= btn_l;
      btn_r_q     <= btn_r;
      armed_q     <= 1'b1;
`ifdef PONG_SPEEDUP_EN
      period_q    <= period_d;
`endif
    end
  end

  assign counter   = counter_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Random play against a game-level reference model; expected outputs per clock are queued
// by the driver and checked by an independent monitor.
module tb_pong_ball_ctrl;

  localparam int STEP = 8;
  localparam int HOLD = 16;
  localparam int WIN  = 7;

  logic       clk_game = 1'b0;
  logic       rst_n    = 1'b0;
  logic       btn_l    = 1'b0;
  logic       btn_r    = 1'b0;
  logic [5:0] counter;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;

  always #5 clk_game = ~clk_game;

  pong_ball_ctrl #(
    .STEP_TICKS(STEP),
    .HOLD_TICKS(HOLD),
    .WIN_SCORE (WIN)
  ) dut (
    .clk_game (clk_game),
    .rst_n    (rst_n),
    .btn_l    (btn_l),
    .btn_r    (btn_r),
    .counter  (counter),
    .score_l  (score_l),
    .score_r  (score_r),
    .game_over(game_over)
  );

  typedef struct packed {
    logic [5:0] counter;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       go;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: the ball is a position plus a direction (+1 toward the left
  // player, -1 toward the right player, 0 when not in play).
  int m_pos, m_dir, m_elapsed, m_period, m_hold_left, m_sl, m_sr;
  bit m_over, m_hit, m_prev_l, m_prev_r, m_armed;
  int n_points  = 0;
  int n_returns = 0;
  int n_games   = 0;
  bit aim_l, aim_r;

  function automatic void model_reset();
    m_pos = 0; m_dir = 0; m_elapsed = 0; m_period = STEP; m_hold_left = 0;
    m_sl = 0; m_sr = 0; m_over = 0; m_hit = 0;
    m_prev_l = 0; m_prev_r = 0; m_armed = 0;
  endfunction

  function automatic void model_serve(int pos, int dir);
    m_pos = pos; m_dir = dir; m_elapsed = 0; m_period = STEP; m_hit = 0;
    $display("serve: from %0d", pos);
  endfunction

  function automatic void model_clock(bit bl, bit br);
    bit pl, pr, own_press;
    int end_pos;
    pl = bl && !m_prev_l && m_armed;
    pr = br && !m_prev_r && m_armed;
    m_prev_l = bl;
    m_prev_r = br;
    m_armed  = 1;
    if (m_over) begin
      if (pl || pr) begin
        m_over = 0; m_sl = 0; m_sr = 0; m_dir = 0;
        $display("new game");
      end
    end else if (m_hold_left > 0) begin
      m_hold_left--;
      if (m_hold_left == 0 && (m_sl == WIN || m_sr == WIN)) begin
        m_over = 1;
        n_games++;
        $display("game over #%0d: score_l=%0d score_r=%0d", n_games, m_sl, m_sr);
      end
    end else if (m_dir == 0) begin
      if (pl)      model_serve(16, -1);
      else if (pr) model_serve(1, 1);
    end else begin
      end_pos   = (m_dir > 0) ? 16 : 1;
      own_press = (m_dir > 0) ? pl : pr;
      if (m_pos == end_pos && own_press) m_hit = 1;
      m_elapsed++;
      if (m_elapsed == m_period) begin
        m_elapsed = 0;
        if (m_pos != end_pos) begin
          m_pos += m_dir;
        end else if (m_hit) begin
          m_dir = -m_dir;
          m_pos += m_dir;
          m_hit = 0;
          n_returns++;
`ifdef PONG_SPEEDUP_EN
          if (m_period > 2) m_period--;
`endif
        end else begin
          if (m_dir > 0) m_sr = (m_sr < WIN) ? m_sr + 1 : m_sr;
          else           m_sl = (m_sl < WIN) ? m_sl + 1 : m_sl;
          m_hold_left = HOLD;
          m_dir = 0;
          m_hit = 0;
          n_points++;
          $display("point #%0d: score_l=%0d score_r=%0d", n_points, m_sl, m_sr);
        end
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    if (m_over)               e.counter = 6'd63;
    else if (m_hold_left > 0) e.counter = 6'd17;
    else if (m_dir == 0)      e.counter = 6'd0;
    else                      e.counter = 6'(m_pos);
    e.sl = 4'(m_sl);
    e.sr = 4'(m_sr);
    e.go = m_over;
    return e;
  endfunction

  task automatic drive_now(input bit bl, input bit br);
    btn_l = bl;
    btn_r = br;
    model_clock(bl, br);
    exp_q.push_back(model_out());
  endtask

  task automatic cycle(input bit bl, input bit br);
    @(negedge clk_game);
    drive_now(bl, br);
  endtask

  task automatic check_reset_now(input string tag);
    exp_t e;
    e = model_out();
    checks++;
    if (counter !== e.counter || score_l !== e.sl || score_r !== e.sr || game_over !== e.go) begin
      failures++;
      $display("FAIL %s: got counter=%0d sl=%0d sr=%0d go=%0b, want counter=%0d sl=%0d sr=%0d go=%0b",
               tag, counter, score_l, score_r, game_over, e.counter, e.sl, e.sr, e.go);
    end
  endtask

  // Reset lands between clock edges so its asynchronous effect is observed before any edge.
  task automatic do_reset(input bit hold_r);
    @(posedge clk_game);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_now("async_reset");
    btn_l = 1'b0;
    btn_r = hold_r;
    @(negedge clk_game);
    @(negedge clk_game);
    rst_n = 1'b1;
    drive_now(1'b0, hold_r);
  endtask

  // Monitor: every clock edge in which a prediction is pending is one transaction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_game);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (counter !== e.counter || score_l !== e.sl || score_r !== e.sr || game_over !== e.go) begin
          failures++;
          $display("FAIL cycle t=%0t: got counter=%0d sl=%0d sr=%0d go=%0b, want counter=%0d sl=%0d sr=%0d go=%0b",
                   $time, counter, score_l, score_r, game_over, e.counter, e.sl, e.sr, e.go);
        end
      end
    end
  end

  initial begin
    bit bl, br;
    model_reset();
    #2;
    check_reset_now("power_on_reset");
    btn_r = 1'b1;
    @(negedge clk_game);
    @(negedge clk_game);
    // btn_r held across reset release must not serve; a fresh rising edge must.
    rst_n = 1'b1;
    drive_now(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (40) cycle(1'b0, 1'b0);

    // Reset mid-rally, then simultaneous presses in idle serve from the left.
    do_reset(1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b1);
    repeat (20) cycle(1'b0, 1'b0);
    do_reset(1'b1);
    cycle(1'b0, 1'b0);

    for (int i = 0; i < 30000; i++) begin
      if (!(m_pos == 16 && m_dir > 0)) aim_l = 1'($urandom % 2);
      if (!(m_pos == 1 && m_dir < 0))  aim_r = 1'($urandom % 2);
      bl = ($urandom % 32 == 0);
      br = ($urandom % 32 == 0);
      if (m_pos == 16 && m_dir > 0 && m_hold_left == 0) bl = aim_l && ($urandom % 3 == 0);
      if (m_pos == 1 && m_dir < 0 && m_hold_left == 0)  br = aim_r && ($urandom % 3 == 0);
      cycle(bl, br);
      if ($urandom % 6000 == 0) do_reset(1'($urandom % 2));
    end

    repeat (3) @(posedge clk_game);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending predictions, want 0", exp_q.size());
    end
    $display("stats: points=%0d returns=%0d games=%0d", n_points, n_returns, n_games);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
